// File: rtl/motoro3_pkg.sv
// rtl/motoro3_pkg.sv - shared state encodings and period defaults for the motoro3 drive
package motoro3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ALIGN    = 3'd1,
    ST_RAMP     = 3'd2,
    ST_RUN      = 3'd3,
    ST_STOPPING = 3'd4,
    ST_FAULT    = 3'd5
  } ctrl_state_e;

  // Reload defaults in 10 MHz clocks; the commutation block uses the same values.
  localparam int DEF_CNT_W        = 25;
  localparam int DEF_START_PERIOD = 666_666;
  localparam int DEF_MIN_PERIOD   = 1_667;
  localparam int DEF_RAMP_STEP    = 8_192;
  localparam int DEF_ALIGN_STEPS  = 6;

endpackage

// File: rtl/motoro3_period_slewer.sv
// rtl/motoro3_period_slewer.sv - moves a period one bounded step toward a goal on each tick
module motoro3_period_slewer #(
  parameter int W = 25
) (
  input  logic [W-1:0] cur_i,
  input  logic [W-1:0] goal_i,
  input  logic [W-1:0] step_i,
  input  logic         tick_i,
  output logic [W-1:0] next_o
);

  logic [W-1:0] dn_gap;
  logic [W-1:0] up_gap;

  // Gaps are only used when the subtraction cannot wrap.
  assign dn_gap = cur_i - goal_i;
  assign up_gap = goal_i - cur_i;

  always_comb begin
    next_o = cur_i;
    if (tick_i) begin
      if (cur_i > goal_i) begin
        next_o = cur_i - ((dn_gap < step_i) ? dn_gap : step_i);
      end else if (cur_i < goal_i) begin
        next_o = cur_i + ((up_gap < step_i) ? up_gap : step_i);
      end
    end
  end

endmodule

// File: rtl/motoro3_ramp_controller.sv
// rtl/motoro3_ramp_controller.sv - soft-start/soft-stop sequencer feeding the 6-step commutator
module motoro3_ramp_controller
  import motoro3_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int START_PERIOD = DEF_START_PERIOD,
  parameter int MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int RAMP_STEP    = DEF_RAMP_STEP,
  parameter int ALIGN_STEPS  = DEF_ALIGN_STEPS
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             cmdRun,
  input  logic             estop,
  input  logic [CNT_W-1:0] targetPeriod,
  input  logic             stepTick,
  output logic             m3start,
  output logic [CNT_W-1:0] m3period,
  output logic [2:0]       ctrlState,
  output logic             atSpeed,
  output logic             fault
);

  localparam int AW = $clog2(ALIGN_STEPS + 1);
  localparam logic [CNT_W-1:0] START_P = CNT_W'(START_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] STEP_P  = CNT_W'(RAMP_STEP);
  localparam logic [AW-1:0]    LAST_ALIGN = AW'(ALIGN_STEPS - 1);

  ctrl_state_e      state_q, state_d;
  logic             m3start_q, m3start_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [AW-1:0]    alignCnt_q, alignCnt_d;
  logic             atSpeed_q, atSpeed_d;

  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] slew_goal;
  logic [CNT_W-1:0] slew_next;
  logic             tick;

  always_comb begin
    if (targetPeriod < MIN_P) begin
      tgt = MIN_P;
    end else if (targetPeriod > START_P) begin
      tgt = START_P;
    end else begin
      tgt = targetPeriod;
    end
  end

  // Ticks only count while the commutator is actually enabled.
  assign tick      = stepTick & m3start_q;
  assign slew_goal = (state_q == ST_STOPPING) ? START_P : tgt;

  motoro3_period_slewer #(
    .W(CNT_W)
  ) u_slewer (
    .cur_i  (period_q),
    .goal_i (slew_goal),
    .step_i (STEP_P),
    .tick_i (tick),
    .next_o (slew_next)
  );

  always_comb begin
    state_d    = state_q;
    m3start_d  = m3start_q;
    period_d   = period_q;
    alignCnt_d = alignCnt_q;
    if (estop) begin
      state_d   = ST_FAULT;
      m3start_d = 1'b0;
      period_d  = START_P;
    end else begin
      case (state_q)
        ST_IDLE: begin
          m3start_d = 1'b0;
          period_d  = START_P;
          if (cmdRun) begin
            state_d    = ST_ALIGN;
            m3start_d  = 1'b1;
            alignCnt_d = '0;
          end
        end
        ST_ALIGN: begin
          period_d = START_P;
          if (!cmdRun) begin
            state_d = ST_STOPPING;
          end else if (tick) begin
            alignCnt_d = alignCnt_q + 1'b1;
            if (alignCnt_q == LAST_ALIGN) begin
              state_d = ST_RAMP;
            end
          end
        end
        ST_RAMP: begin
          if (!cmdRun) begin
            state_d = ST_STOPPING;
          end else begin
            period_d = slew_next;
            if (period_q == tgt) begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!cmdRun) begin
            state_d = ST_STOPPING;
          end else if (period_q != tgt) begin
            state_d = ST_RAMP;
          end
        end
        ST_STOPPING: begin
          // Resume straight into RAMP from wherever the period has reached.
          if (cmdRun) begin
            state_d = ST_RAMP;
          end else if (tick) begin
            if (period_q == START_P) begin
              state_d   = ST_IDLE;
              m3start_d = 1'b0;
            end else begin
              period_d = slew_next;
            end
          end
        end
        ST_FAULT: begin
          m3start_d = 1'b0;
          period_d  = START_P;
          if (!cmdRun) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          m3start_d = 1'b0;
          period_d  = START_P;
        end
      endcase
    end
    atSpeed_d = (state_d == ST_RUN) && (period_d == tgt);
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      m3start_q  <= 1'b0;
      period_q   <= START_P;
      alignCnt_q <= '0;
      atSpeed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      m3start_q  <= m3start_d;
      period_q   <= period_d;
      alignCnt_q <= alignCnt_d;
      atSpeed_q  <= atSpeed_d;
    end
  end

  assign m3start   = m3start_q;
  assign m3period  = period_q;
  assign ctrlState = state_q;
  assign atSpeed   = atSpeed_q;
  assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_motoro3_ramp_controller.sv
// tb/tb_motoro3_ramp_controller.sv - directed bench for the motoro3 ramp controller
module tb_motoro3_ramp_controller;

  localparam int CNT_W = 25;

  logic             clk = 1'b0;
  logic             nRst;
  logic             cmdRun;
  logic             estop;
  logic [CNT_W-1:0] targetPeriod;
  logic             stepTick;
  logic             m3start;
  logic [CNT_W-1:0] m3period;
  logic [2:0]       ctrlState;
  logic             atSpeed;
  logic             fault;

  int total = 0;
  int bad   = 0;

  motoro3_ramp_controller #(
    .CNT_W        (CNT_W),
    .START_PERIOD (1000),
    .MIN_PERIOD   (100),
    .RAMP_STEP    (300),
    .ALIGN_STEPS  (2)
  ) dut (
    .clk          (clk),
    .nRst         (nRst),
    .cmdRun       (cmdRun),
    .estop        (estop),
    .targetPeriod (targetPeriod),
    .stepTick     (stepTick),
    .m3start      (m3start),
    .m3period     (m3period),
    .ctrlState    (ctrlState),
    .atSpeed      (atSpeed),
    .fault        (fault)
  );

  always #50 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One stepTick pulse, then idle so ticks land every 20 cycles.
  task automatic tick();
    @(posedge clk);
    stepTick = 1'b1;
    @(posedge clk);
    stepTick = 1'b0;
    cyc(18);
  endtask

  task automatic chk_state(input string tag, input int st, input int per);
    check_eq({tag, ".state"}, 32'(ctrlState), 32'(st));
    check_eq({tag, ".period"}, 32'(m3period), 32'(per));
  endtask

  initial begin
    nRst = 1'b0; cmdRun = 1'b0; estop = 1'b0; targetPeriod = 25'd250; stepTick = 1'b0;
    cyc(2);
    check_eq("rst.m3start", 32'(m3start), 0);
    chk_state("rst", 0, 1000);
    check_eq("rst.atSpeed", 32'(atSpeed), 0);
    check_eq("rst.fault", 32'(fault), 0);
    nRst = 1'b1;
    cyc(2);

    // 1: start, align two ticks, ramp 700/400/250, run
    cmdRun = 1'b1;
    cyc(1);
    check_eq("start.m3start", 32'(m3start), 1);
    chk_state("start", 1, 1000);
    tick(); chk_state("align1", 1, 1000);
    tick(); chk_state("align2", 2, 1000);
    tick(); check_eq("ramp1.period", 32'(m3period), 700);
    tick(); check_eq("ramp2.period", 32'(m3period), 400);
    tick(); chk_state("ramp3", 3, 250);
    check_eq("run1.atSpeed", 32'(atSpeed), 1);

    // 3: stop from 250
    cmdRun = 1'b0;
    cyc(1); chk_state("stop0", 4, 250);
    check_eq("stop0.atSpeed", 32'(atSpeed), 0);
    tick(); chk_state("stop1", 4, 550);
    tick(); chk_state("stop2", 4, 850);
    tick(); chk_state("stop3", 4, 1000);
    check_eq("stop3.m3start", 32'(m3start), 1);
    tick(); chk_state("stop4", 0, 1000);
    check_eq("stop4.m3start", 32'(m3start), 0);

    // 2: low clamp lands on 100, high clamp lands on 1000
    targetPeriod = 25'd10;
    cmdRun = 1'b1;
    cyc(1);
    tick(); tick();
    tick(); check_eq("clo1.period", 32'(m3period), 700);
    tick(); check_eq("clo2.period", 32'(m3period), 400);
    tick(); chk_state("clo3", 3, 100);
    check_eq("clo3.atSpeed", 32'(atSpeed), 1);
    targetPeriod = 25'd5000;
    cyc(1); chk_state("chi0", 2, 100);
    check_eq("chi0.atSpeed", 32'(atSpeed), 0);
    tick(); check_eq("chi1.period", 32'(m3period), 400);
    tick(); check_eq("chi2.period", 32'(m3period), 700);
    tick(); chk_state("chi3", 3, 1000);
    check_eq("chi3.atSpeed", 32'(atSpeed), 1);

    // 4: back down to 250, stop one tick, resume without align
    targetPeriod = 25'd250;
    tick(); tick(); tick();
    chk_state("down", 3, 250);
    cmdRun = 1'b0;
    cyc(1);
    tick(); chk_state("res0", 4, 550);
    cmdRun = 1'b1;
    cyc(1); chk_state("res1", 2, 550);
    tick(); chk_state("res2", 3, 250);

    // 5: estop mid-ramp
    targetPeriod = 25'd1000;
    tick(); chk_state("es0", 2, 550);
    estop = 1'b1;
    cyc(1); chk_state("es1", 5, 1000);
    check_eq("es1.m3start", 32'(m3start), 0);
    check_eq("es1.fault", 32'(fault), 1);
    estop = 1'b0;
    cyc(3); check_eq("es2.state", 32'(ctrlState), 5);
    cmdRun = 1'b0;
    cyc(1); check_eq("es3.state", 32'(ctrlState), 0);
    check_eq("es3.fault", 32'(fault), 0);

    // 6: async reset mid-run
    targetPeriod = 25'd250;
    cmdRun = 1'b1;
    cyc(1);
    tick(); tick(); tick(); tick(); tick();
    chk_state("pre_rst", 3, 250);
    #20;
    nRst = 1'b0;
    #1;
    chk_state("arst", 0, 1000);
    check_eq("arst.m3start", 32'(m3start), 0);
    check_eq("arst.atSpeed", 32'(atSpeed), 0);
    cmdRun = 1'b0;
    @(posedge clk);
    nRst = 1'b1;
    tick(); chk_state("post_rst", 0, 1000);
    check_eq("post_rst.m3start", 32'(m3start), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
